// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the unified memory port arbiter.
//   state_t    : sequencing FSM states (IDLE -> ISSUE -> WAIT)
//   owner_t    : which requester owns the in-flight access
//   MEM_CTRL_W : width of the load/store width code (funct3)
//   FETCH_CTRL : width code forced for instruction fetches (word)
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } state_t;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_D  = 1'b1
  } owner_t;

  localparam int MEM_CTRL_W = 3;
  localparam logic [MEM_CTRL_W-1:0] FETCH_CTRL = 3'b010;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bundle of the fetch, data and memory-side signals around the arbiter.
//   fetch side : if_req/if_addr/if_flush in, if_rdata/if_valid/if_stall out
//   data side  : d_req/d_we/d_addr/d_wdata/d_ctrl in, d_rdata/d_valid/d_stall out
//   memory side: mem_en/mem_we/mem_addr/mem_wdata/mem_ctrl out, mem_rdata in
// Modports: master = arbiter view, slave = pipeline/memory environment view.
interface mem_port_arbiter_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  import mem_arb_pkg::*;

  logic                  if_req;
  logic [ADDR_WIDTH-1:0] if_addr;
  logic                  if_flush;
  logic [DATA_WIDTH-1:0] if_rdata;
  logic                  if_valid;
  logic                  if_stall;

  logic                  d_req;
  logic                  d_we;
  logic [ADDR_WIDTH-1:0] d_addr;
  logic [DATA_WIDTH-1:0] d_wdata;
  logic [MEM_CTRL_W-1:0] d_ctrl;
  logic [DATA_WIDTH-1:0] d_rdata;
  logic                  d_valid;
  logic                  d_stall;

  logic                  mem_en;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic [MEM_CTRL_W-1:0] mem_ctrl;
  logic [DATA_WIDTH-1:0] mem_rdata;

  modport master (
    input  if_req, if_addr, if_flush,
    output if_rdata, if_valid, if_stall,
    input  d_req, d_we, d_addr, d_wdata, d_ctrl,
    output d_rdata, d_valid, d_stall,
    output mem_en, mem_we, mem_addr, mem_wdata, mem_ctrl,
    input  mem_rdata
  );

  modport slave (
    output if_req, if_addr, if_flush,
    input  if_rdata, if_valid, if_stall,
    output d_req, d_we, d_addr, d_wdata, d_ctrl,
    input  d_rdata, d_valid, d_stall,
    input  mem_en, mem_we, mem_addr, mem_wdata, mem_ctrl,
    output mem_rdata
  );

endinterface

// File: rtl/mem_port_arbiter.sv
// Shares the single memory port between instruction fetch and the memory
// stage. One access in flight: grant in IDLE, strobe memory for one cycle in
// ISSUE, wait MEM_LATENCY cycles in WAIT and pulse the owner's valid in the
// last of them. Data wins arbitration unless fetch has waited through
// MAX_D_STREAK consecutive data grants.
// Ports:
//   clk : rising-edge clock
//   rst : asynchronous active-high reset
//   bus : mem_port_arbiter_if.master (fetch, data and memory signals)
module mem_port_arbiter #(
  parameter int ADDR_WIDTH   = 32,
  parameter int DATA_WIDTH   = 32,
  parameter int MEM_LATENCY  = 2,
  parameter int MAX_D_STREAK = 4
) (
  input logic                clk,
  input logic                rst,
  mem_port_arbiter_if.master bus
);
  import mem_arb_pkg::*;

  // Counter only has to hold MEM_LATENCY-1, loaded in ISSUE.
  localparam int CNT_W    = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
  localparam int STREAK_W = $clog2(MAX_D_STREAK + 1);
  localparam logic [CNT_W-1:0]    LAT_LOAD   = CNT_W'(MEM_LATENCY - 1);
  localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_D_STREAK);

  state_t                state;
  state_t                next_state;
  owner_t                owner;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic                  we_q;
  logic [MEM_CTRL_W-1:0] ctrl_q;
  logic [CNT_W-1:0]      cnt;
  logic [STREAK_W-1:0]   streak;
  logic                  kill;

  logic grant_d;
  logic grant_if;
  logic last_wait;
  logic issue;
  logic if_ok;
  logic d_ok;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  // Next-state, arbitration and all bus outputs. A flush arriving in the
  // very last WAIT cycle must still suppress if_valid, hence the direct
  // if_flush term alongside the registered kill flag.
  always_comb begin
    next_state = state;
    grant_d    = 1'b0;
    grant_if   = 1'b0;
    last_wait  = 1'b0;
    case (state)
      IDLE: begin
        grant_d  = bus.d_req && !(bus.if_req && (streak == STREAK_MAX));
        grant_if = bus.if_req && !grant_d;
        if (grant_d || grant_if) next_state = ISSUE;
      end
      ISSUE: next_state = WAIT;
      WAIT: begin
        if (cnt == '0) begin
          last_wait  = 1'b1;
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase

    issue = (state == ISSUE);
    if_ok = last_wait && (owner == OWN_IF) && !kill && !bus.if_flush;
    d_ok  = last_wait && (owner == OWN_D);

    bus.mem_en    = issue;
    bus.mem_we    = issue && we_q;
    bus.mem_addr  = issue ? addr_q  : '0;
    bus.mem_wdata = issue ? wdata_q : '0;
    bus.mem_ctrl  = issue ? ctrl_q  : '0;

    bus.if_valid = if_ok;
    bus.if_rdata = if_ok ? bus.mem_rdata : '0;
    bus.d_valid  = d_ok;
    bus.d_rdata  = (d_ok && !we_q) ? bus.mem_rdata : '0;
    bus.if_stall = bus.if_req && !if_ok;
    bus.d_stall  = bus.d_req && !d_ok;
  end

  // Request capture, streak tracking, latency countdown and fetch kill.
  // Fetch captures are normalised (read, word, zero data) so ISSUE can
  // drive mem_* straight from the registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      owner   <= OWN_IF;
      addr_q  <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
      ctrl_q  <= '0;
      streak  <= '0;
      cnt     <= '0;
      kill    <= 1'b0;
    end else begin
      if (grant_d) begin
        owner   <= OWN_D;
        addr_q  <= bus.d_addr;
        wdata_q <= bus.d_wdata;
        we_q    <= bus.d_we;
        ctrl_q  <= bus.d_ctrl;
        if (!bus.if_req)               streak <= '0;
        else if (streak != STREAK_MAX) streak <= streak + 1'b1;
      end else if (grant_if) begin
        owner   <= OWN_IF;
        addr_q  <= bus.if_addr;
        wdata_q <= '0;
        we_q    <= 1'b0;
        ctrl_q  <= FETCH_CTRL;
        streak  <= '0;
      end

      if (state == ISSUE)                    cnt <= LAT_LOAD;
      else if (state == WAIT && cnt != '0)   cnt <= cnt - 1'b1;

      if (last_wait)
        kill <= 1'b0;
      else if (state != IDLE && owner == OWN_IF && bus.if_flush)
        kill <= 1'b1;
    end
  end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Sequencing controller that shares the single unified memory port between the instruction-fetch stage and the memory stage of the pipelined core. It grants one requester at a time, drives the memory for a fixed-latency access, and returns read data with a one-cycle valid pulse. It also generates the per-requester stall signals that freeze the pipeline while an access is pending or waiting for arbitration. Data accesses have priority, with a streak limit that guarantees fetch forward progress.

## Interface
- ADDR_WIDTH, 32, byte address width
- DATA_WIDTH, 32, data width
- MEM_LATENCY, 2, cycles from mem_en to valid mem_rdata (≥1)
- MAX_D_STREAK, 4, consecutive data grants allowed while fetch waits
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- if_req  in  1  fetch request, level, held until if_valid
- if_addr  in  ADDR_WIDTH  fetch address
- if_flush  in  1  discard in-flight fetch (branch/jump redirect)
- if_rdata  out  DATA_WIDTH  fetched instruction
- if_valid  out  1  one-cycle fetch completion pulse
- if_stall  out  1  fetch stage must hold
- d_req  in  1  load/store request, level, held until d_valid
- d_we  in  1  1 = store
- d_addr  in  ADDR_WIDTH  data address
- d_wdata  in  DATA_WIDTH  store data
- d_ctrl  in  3  load/store width code (funct3 encoding)
- d_rdata  out  DATA_WIDTH  load data
- d_valid  out  1  one-cycle data completion pulse
- d_stall  out  1  memory stage must hold
- mem_en  out  1  memory access strobe, one cycle per access
- mem_we  out  1  memory write enable
- mem_addr  out  ADDR_WIDTH  memory address
- mem_wdata  out  DATA_WIDTH  memory write data
- mem_ctrl  out  3  width code to memory (fetch forces 3'b010)
- mem_rdata  in  DATA_WIDTH  memory read data

## Operation
- FSM states: IDLE, ISSUE, WAIT. One transaction outstanding at most.
- IDLE: if any req, choose owner, register addr/wdata/we/ctrl, go ISSUE; else stay.
- Arbitration: d_req wins unless if_req=1 and streak==MAX_D_STREAK, in which case fetch wins.
- Streak counter: +1 on each data grant while if_req=1; cleared on fetch grant or on data grant with if_req=0; saturates at MAX_D_STREAK.
- ISSUE: mem_en=1 and mem_* from registers for exactly one cycle; latency counter loaded; go WAIT.
- WAIT: count MEM_LATENCY cycles; in the last WAIT cycle assert owner's valid, then return to IDLE.
- Fetch owner: mem_we=0, mem_ctrl=3'b010, mem_wdata=0.
- if_rdata = mem_rdata when if_valid, else 0. d_rdata = mem_rdata when d_valid and load, else 0. A store still pulses d_valid.
- if_flush=1 during any cycle of an owned fetch (ISSUE/WAIT) sets a kill flag: memory access completes, but if_valid is suppressed. The kill flag clears on return to IDLE. if_flush in IDLE has no effect.
- if_stall = if_req & ~if_valid; d_stall = d_req & ~d_valid (combinational).
- A requester whose req is still high in the IDLE cycle after its valid pulse is treated as a new request.

## Timing
- Request seen in IDLE at cycle T: mem_en at T+1; valid at T+1+MEM_LATENCY; IDLE at T+2+MEM_LATENCY.
- Request-to-valid latency is MEM_LATENCY+1 cycles, plus any arbitration wait.
- Back-to-back accesses repeat every MEM_LATENCY+2 cycles.
- Simultaneous if_req and d_req in IDLE: single grant per the streak rule; the loser keeps its stall asserted.
- Reset (asynchronous, any state): state=IDLE, streak=0, kill=0, counter=0.
- Reset values: mem_en, mem_we, if_valid, d_valid are 0; mem_addr, mem_wdata, mem_ctrl, if_rdata, d_rdata are 0; stalls follow their req inputs.
- Reset mid-transaction drops the access with no valid pulse.

## Structure
- Shared package mem_arb_pkg holds:
  - state enum {IDLE, ISSUE, WAIT}
  - owner enum {OWN_IF, OWN_D}
  - MEM_CTRL_W = 3
  - FETCH_CTRL = 3'b010
- No sub-module; the FSM, streak counter and latency counter live in one module.

## Test plan
- Single load, MEM_LATENCY=2: d_req at T, addr 0x100, mem_rdata=0xDEADBEEF → mem_en at T+1, d_valid and d_rdata=0xDEADBEEF at T+3, d_stall high T..T+2.
- Store d_wdata=0x12345678, d_ctrl=3'b000 → mem_we=1, mem_ctrl=3'b000 on the mem_en cycle; d_valid pulse; d_rdata=0.
- Both requests held continuously, MAX_D_STREAK=4 → grant order D,D,D,D,IF,D,…; if_stall high throughout the four data transactions.
- Fetch in flight, if_flush pulsed in WAIT → no if_valid, FSM returns to IDLE on schedule, next if_req accepted normally.
- rst asserted asynchronously mid-WAIT → outputs zero immediately, no valid pulse; after release, a fresh fetch completes with latency 3.
